// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - cascadable BCD modulo counter with up/down count and sanitised preset load
// State is the tens/ones digit pair; Carry_out is combinational so chained stages wrap on the same edge.
module bcd_mod_counter #(
  parameter int MODULUS   = 24,
  parameter int MIN_VAL   = 0,
  parameter int RESET_VAL = MIN_VAL
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       EN,
  input  logic       Carry,
  input  logic       Down,
  input  logic       Load,
  input  logic [3:0] set0,
  input  logic [3:0] set1,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       Carry_out
);

  localparam int         MAX_VAL = MIN_VAL + MODULUS - 1;
  localparam logic [3:0] MAX_T   = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_O   = 4'(MAX_VAL % 10);
  localparam logic [3:0] MIN_T   = 4'(MIN_VAL / 10);
  localparam logic [3:0] MIN_O   = 4'(MIN_VAL % 10);
  localparam logic [3:0] RST_T   = 4'(RESET_VAL / 10);
  localparam logic [3:0] RST_O   = 4'(RESET_VAL % 10);
  localparam logic [6:0] MAX_V   = 7'(MAX_VAL);

  if (MODULUS < 2 || MAX_VAL > 99 || (MIN_VAL != 0 && MIN_VAL != 1) ||
      RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL) begin : g_bad_params
    $error("bcd_mod_counter: illegal parameter combination");
  end

  logic       at_max;
  logic       at_min;
  logic       terminal;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [6:0] v;
  logic [3:0] nxt_t;
  logic [3:0] nxt_o;

  assign at_max   = (tens == MAX_T) && (ones == MAX_O);
  assign at_min   = (tens == MIN_T) && (ones == MIN_O);
  assign terminal = Down ? at_min : at_max;

  // Reset gating keeps Carry_out low even when RESET_VAL happens to be terminal
  assign Carry_out = RST_n & EN & ~Load & Carry & terminal;

  assign d0 = (set0 > 4'd9) ? 4'd9 : set0;
  assign d1 = (set1 > 4'd9) ? 4'd9 : set1;
  assign v  = 7'(d1) * 7'd10 + 7'(d0);

  always_comb begin
    nxt_t = tens;
    nxt_o = ones;
    if (Load) begin
      // MIN_VAL is 0 or 1, so "below minimum" can only mean a preset of 00 with MIN_VAL=1
      if (v > MAX_V) begin
        nxt_t = MAX_T;
        nxt_o = MAX_O;
      end else if (v == 7'd0 && MIN_VAL != 0) begin
        nxt_t = MIN_T;
        nxt_o = MIN_O;
      end else begin
        nxt_t = d1;
        nxt_o = d0;
      end
    end else if (Carry) begin
      if (!Down) begin
        if (at_max) begin
          nxt_t = MIN_T;
          nxt_o = MIN_O;
        end else if (ones == 4'd9) begin
          nxt_o = 4'd0;
          nxt_t = tens + 4'd1;
        end else begin
          nxt_o = ones + 4'd1;
        end
      end else begin
        if (at_min) begin
          nxt_t = MAX_T;
          nxt_o = MAX_O;
        end else if (ones == 4'd0) begin
          nxt_o = 4'd9;
          nxt_t = tens - 4'd1;
        end else begin
          nxt_o = ones - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      tens <= RST_T;
      ones <= RST_O;
    end else if (EN) begin
      tens <= nxt_t;
      ones <= nxt_o;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb/tb_bcd_mod_counter.sv - directed self-checking bench for bcd_mod_counter
module tb_bcd_mod_counter;

  logic       clk;
  logic       rst_n;
  logic       en, carry, down, load;
  logic [3:0] set0, set1;
  logic       en_c, carry_c, load_c;
  logic [3:0] set0_l, set1_l, set0_h, set1_h;

  logic [3:0] def_o, def_t, m12_o, m12_t, m100_o, m100_t, lo_o, lo_t, hi_o, hi_t;
  logic       def_co, m12_co, m100_co, lo_co, hi_co;

  int checks   = 0;
  int failures = 0;

  bcd_mod_counter u_def (
    .CLK(clk), .RST_n(rst_n), .EN(en), .Carry(carry), .Down(down), .Load(load),
    .set0(set0), .set1(set1), .ones(def_o), .tens(def_t), .Carry_out(def_co));

  bcd_mod_counter #(.MODULUS(12), .MIN_VAL(1)) u_m12 (
    .CLK(clk), .RST_n(rst_n), .EN(en), .Carry(carry), .Down(down), .Load(load),
    .set0(set0), .set1(set1), .ones(m12_o), .tens(m12_t), .Carry_out(m12_co));

  bcd_mod_counter #(.MODULUS(100)) u_m100 (
    .CLK(clk), .RST_n(rst_n), .EN(en), .Carry(carry), .Down(down), .Load(load),
    .set0(set0), .set1(set1), .ones(m100_o), .tens(m100_t), .Carry_out(m100_co));

  bcd_mod_counter #(.MODULUS(60)) u_lo (
    .CLK(clk), .RST_n(rst_n), .EN(en_c), .Carry(carry_c), .Down(down), .Load(load_c),
    .set0(set0_l), .set1(set1_l), .ones(lo_o), .tens(lo_t), .Carry_out(lo_co));

  bcd_mod_counter #(.MODULUS(24), .RESET_VAL(12)) u_hi (
    .CLK(clk), .RST_n(rst_n), .EN(en_c), .Carry(lo_co), .Down(down), .Load(load_c),
    .set0(set0_h), .set1(set1_h), .ones(hi_o), .tens(hi_t), .Carry_out(hi_co));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [3:0] t, input logic [3:0] o);
    load = 1'b1;
    set1 = t;
    set0 = o;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; carry = 1'b0; down = 1'b0; load = 1'b0; set0 = '0; set1 = '0;
    en_c = 1'b0; carry_c = 1'b0; load_c = 1'b0;
    set0_l = '0; set1_l = '0; set0_h = '0; set1_h = '0;
    #12;
    check("rst_def", {def_t, def_o}, 8'h00);
    check("rst_m12", {m12_t, m12_o}, 8'h01);
    check("rst_hi", {hi_t, hi_o}, 8'h12);
    rst_n = 1'b1;
    en = 1'b1;
    en_c = 1'b1;

    // full up sweep with wrap
    carry = 1'b1;
    #1;
    for (int i = 0; i < 24; i++) begin
      check($sformatf("sweep_val%0d", i), {def_t, def_o}, {4'(i / 10), 4'(i % 10)});
      check($sformatf("sweep_co%0d", i), {7'd0, def_co}, {7'd0, (i == 23)});
      tick();
    end
    check("sweep_wrap", {def_t, def_o}, 8'h00);
    carry = 1'b0;

    ld(4'd3, 4'd7);
    check("load_clamp_hi", {def_t, def_o}, 8'h23);
    load = 1'b1; carry = 1'b1; set1 = 4'd1; set0 = 4'd12;
    #1;
    check("load_masks_co", {7'd0, def_co}, 8'h00);
    tick();
    load = 1'b0; carry = 1'b0;
    check("load_digit_clamp", {def_t, def_o}, 8'h19);

    ld(4'd1, 4'd0);
    check("load_10", {def_t, def_o}, 8'h10);
    down = 1'b1; carry = 1'b1;
    tick();
    carry = 1'b0;
    check("down_borrow", {def_t, def_o}, 8'h09);
    ld(4'd1, 4'd0);
    load = 1'b1; carry = 1'b1; set1 = 4'd0; set0 = 4'd5;
    #1;
    check("load_pri_co", {7'd0, def_co}, 8'h00);
    tick();
    load = 1'b0; carry = 1'b0;
    check("load_pri_val", {def_t, def_o}, 8'h05);

    ld(4'd0, 4'd0);
    carry = 1'b1;
    #1;
    check("down_wrap_co", {7'd0, def_co}, 8'h01);
    tick();
    carry = 1'b0; down = 1'b0;
    check("down_wrap_val", {def_t, def_o}, 8'h23);
    tick();
    check("hold_no_carry", {def_t, def_o}, 8'h23);

    ld(4'd1, 4'd5);
    en = 1'b0; carry = 1'b1; load = 1'b1; set1 = 4'd0; set0 = 4'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("en_off_co%0d", i), {7'd0, def_co}, 8'h00);
      tick();
      check($sformatf("en_off_val%0d", i), {def_t, def_o}, 8'h15);
    end
    en = 1'b1; load = 1'b0; carry = 1'b0;

    ld(4'd1, 4'd2);
    check("m12_load12", {m12_t, m12_o}, 8'h12);
    carry = 1'b1;
    #1;
    check("m12_up_co", {7'd0, m12_co}, 8'h01);
    tick();
    check("m12_up_wrap", {m12_t, m12_o}, 8'h01);
    down = 1'b1;
    #1;
    check("m12_dn_co", {7'd0, m12_co}, 8'h01);
    tick();
    check("m12_dn_wrap", {m12_t, m12_o}, 8'h12);
    carry = 1'b0; down = 1'b0;
    ld(4'd0, 4'd0);
    check("m12_clamp_lo", {m12_t, m12_o}, 8'h01);
    ld(4'd1, 4'd5);
    check("m12_clamp_hi", {m12_t, m12_o}, 8'h12);

    ld(4'd9, 4'd9);
    check("m100_load99", {m100_t, m100_o}, 8'h99);
    carry = 1'b1;
    #1;
    check("m100_up_co", {7'd0, m100_co}, 8'h01);
    tick();
    check("m100_up_wrap", {m100_t, m100_o}, 8'h00);
    down = 1'b1;
    #1;
    check("m100_dn_co", {7'd0, m100_co}, 8'h01);
    tick();
    check("m100_dn_wrap", {m100_t, m100_o}, 8'h99);
    carry = 1'b0; down = 1'b0;

    load_c = 1'b1; set1_l = 4'd5; set0_l = 4'd9; set1_h = 4'd2; set0_h = 4'd3;
    tick();
    load_c = 1'b0;
    check("chain_lo59", {lo_t, lo_o}, 8'h59);
    check("chain_hi23", {hi_t, hi_o}, 8'h23);
    carry_c = 1'b1;
    #1;
    check("chain_lo_co", {7'd0, lo_co}, 8'h01);
    check("chain_hi_co", {7'd0, hi_co}, 8'h01);
    tick();
    check("chain_lo_wrap", {lo_t, lo_o}, 8'h00);
    check("chain_hi_wrap", {hi_t, hi_o}, 8'h00);
    tick();
    check("chain_lo_step", {lo_t, lo_o}, 8'h01);
    check("chain_hi_hold", {hi_t, hi_o}, 8'h00);

    ld(4'd1, 4'd7);
    #2;
    rst_n = 1'b0; carry = 1'b1; down = 1'b1;
    #1;
    check("arst_def", {def_t, def_o}, 8'h00);
    check("arst_co", {7'd0, def_co}, 8'h00);
    check("arst_lo", {lo_t, lo_o}, 8'h00);
    check("arst_hi", {hi_t, hi_o}, 8'h12);
    check("arst_m12", {m12_t, m12_o}, 8'h01);
    rst_n = 1'b1;
    #1;
    check("rel_co", {7'd0, def_co}, 8'h01);
    tick();
    check("rel_first_edge", {def_t, def_o}, 8'h23);
    carry = 1'b0; down = 1'b0; carry_c = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock port CLK, reset port RST_n.
REQ-002 The block SHALL expose the following parameters (name, default, meaning):
- MODULUS, 24: number of count states; legal range 2..100.
- MIN_VAL, 0: lowest count value, 0 or 1; 1 supports 1..12 style counters.
- RESET_VAL, MIN_VAL: count value after reset; must lie in MIN_VAL..MAX_VAL.

REQ-003 MAX_VAL SHALL be derived as MIN_VAL+MODULUS-1 and SHALL be at most 99.

REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- CLK, in, 1: clock, rising edge.
- RST_n, in, 1: async reset, active low.
- EN, in, 1: block enable; when 0, count and load are both frozen.
- Carry, in, 1: count request (carry from the lower stage).
- Down, in, 1: direction; 0 = increment, 1 = decrement.
- Load, in, 1: synchronous preset request.
- set0, in, 4: preset ones digit (BCD).
- set1, in, 4: preset tens digit (BCD).
- ones, out, 4: current ones digit (BCD), registered.
- tens, out, 4: current tens digit (BCD), registered.
- Carry_out, out, 1: wrap indication for the next stage, combinational.

Function
REQ-005 State SHALL be the ones/tens register pair itself; outputs SHALL reflect state with zero added latency (no shadow copy).
REQ-006 On each rising CLK edge, priority SHALL be: Load, then count, then hold; all are gated by EN=1.
REQ-007 Load path (EN=1, Load=1): Carry and Down SHALL be ignored that cycle.
REQ-008 Load sanitising, step 1: any preset digit greater than 9 SHALL be replaced by 9.
REQ-009 Load sanitising, step 2: V=10*set1+set0 SHALL be clamped to MAX_VAL if above it, and to MIN_VAL if below it.
REQ-010 Load sanitising, step 3: the sanitised V SHALL be written to tens/ones on that edge.
REQ-011 Count up (EN=1, Load=0, Carry=1, Down=0): at MAX_VAL the next value SHALL be MIN_VAL; otherwise it SHALL be value+1, with ones 9 -> 0 and tens incremented.
REQ-012 Count down (EN=1, Load=0, Carry=1, Down=1): at MIN_VAL the next value SHALL be MAX_VAL; otherwise it SHALL be value-1, with ones 0 -> 9 and tens decremented.
REQ-013 Carry=0, or EN=0, SHALL hold the value.
REQ-014 Carry_out SHALL equal EN & ~Load & Carry & terminal, where terminal = (value==MAX_VAL) when Down=0 and (value==MIN_VAL) when Down=1.
REQ-015 Carry_out SHALL be valid in the same cycle so that chained stages wrap on the same edge.
REQ-016 ones SHALL always be 0..9, and tens*10+ones SHALL always be within MIN_VAL..MAX_VAL.
REQ-017 No illegal state SHALL be reachable.
REQ-018 MODULUS=100 with MIN_VAL=0 SHALL wrap 99 <-> 00.
REQ-019 Carry held high continuously SHALL advance one step per clock, with no skipped or repeated values across the wrap.

Reset
REQ-020 RST_n=0 SHALL immediately, without CLK, force tens/ones to the BCD digits of RESET_VAL.
REQ-021 While RST_n=0, Carry_out SHALL be 0 regardless of other inputs.
REQ-022 Release of RST_n SHALL be recognised on the first CLK edge after deassertion.
REQ-023 Reset asserted mid-load or mid-wrap SHALL win; no partial digit update SHALL be visible after reset.

Verification
REQ-024 Defaults, reset value 00, Carry=1 for 24 clocks: outputs 00,01,..,23,00; Carry_out high only in the cycle showing 23.
REQ-025 Defaults, Load with set1=3, set0=7 (value 37): 23 loaded; then Load with set1=1, set0=12: digit clamp to 19 loaded.
REQ-026 MODULUS=12, MIN_VAL=1, at 12, Carry=1 Down=0: next value 01; at 01, Down=1: next value 12, Carry_out=1 in that cycle.
REQ-027 Defaults, value 10, Down=1, Carry=1: next value 09. Same value, Load=1 and Carry=1 together with set=05: 05, Carry_out=0.
REQ-028 Defaults, value 15, EN=0 with Carry=1 and Load=1 for 3 clocks: value 15 held, Carry_out=0.
REQ-029 Two instances chained (60 then 24) with Carry_out feeding Carry, low stage at 59 and high stage at 23, one step: both stages 00 on the same edge. Then RST_n pulsed low between edges: outputs at RESET_VAL before the next edge.
